// File: rtl/uart_stream_tx.sv
// Byte-stream UART transmitter: ready/valid input into a small FIFO, 8N1 serial
// output with a registered txd and a programmable bit period.
module uart_stream_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_AW     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_tdata,
  input  logic               s_tvalid,
  output logic               s_tready,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int              DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL   = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [15:0]     BIT_END = 16'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [7:0]         shift;
  logic [2:0]         bit_cnt;
  logic [15:0]        baud_cnt;
  logic               push;
  logic               pop;
  logic               bit_end;

  // Ready looks only at the registered count, so a full FIFO never takes a
  // byte on the same edge it pops one.
  assign s_tready = (fifo_count != FULL);
  assign push     = s_tvalid && s_tready;
  assign pop      = (state == IDLE) && (fifo_count != '0);
  assign bit_end  = (baud_cnt == BIT_END);
  assign busy     = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pop)
      shift <= mem[rd_ptr];
    else if (state == DATA && bit_end)
      shift <= {1'b0, shift[7:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      txd      <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      if (state == IDLE) baud_cnt <= '0;
      else               baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (pop) begin
            txd     <= 1'b0;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            txd   <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            // shift[1] is the bit that becomes shift[0] on this same edge.
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd     <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (bit_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Directed bench for uart_stream_tx at CLK_PER_BIT=4, FIFO_AW=2 with a
// serial decoder that reconstructs transmitted bytes and their start cycles.
module tb_uart_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic       frame_err = 1'b0;
  logic       over_flag = 1'b0;

  uart_stream_tx #(.CLK_PER_BIT(4), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && fifo_count > 3'd4) over_flag = 1'b1;
  end

  // Serial decoder: samples the middle of each 4-cycle bit.
  always begin : decoder
    logic [7:0] b;
    int         t0;
    @(negedge clk);
    if (rst_n === 1'b1 && txd === 1'b0) begin
      t0 = cyc;
      b  = 8'h00;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (4) @(negedge clk);
        b[i] = txd;
      end
      repeat (4) @(negedge clk);
      if (txd !== 1'b1) frame_err = 1'b1;
      rx_q.push_back(b);
      rx_t.push_back(t0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    frame_err = 1'b0;
  endtask

  // Offers a byte and returns at the negedge after the accepting edge,
  // leaving s_tvalid high so calls can be chained back-to-back.
  task automatic push(input logic [7:0] b);
    int k = 0;
    s_tvalid = 1'b1;
    s_tdata  = b;
    while (!s_tready && k < 200) begin
      chk("ready_vs_count", 32'(s_tready), 32'(fifo_count != 3'd4));
      @(negedge clk);
      k++;
    end
    chk("push_ready", 32'(s_tready), 32'd1);
    exp_q.push_back(b);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (rx_q.size() < n && k < n * 60 + 200) begin
      @(negedge clk);
      k++;
    end
    repeat (60) @(negedge clk);
    chk("rx_count", 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      chk($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    chk("framing", 32'(frame_err), 32'd0);
  endtask

  // Called at the negedge right after the start-bit edge; ends 40 cycles on.
  task automatic check_frame(input logic [7:0] b);
    logic e;
    for (int k = 0; k < 40; k++) begin
      if (k < 4)       e = 1'b0;
      else if (k < 36) e = b[(k - 4) / 4];
      else             e = 1'b1;
      chk($sformatf("txd_cycle%0d", k), 32'(txd), 32'(e));
      @(negedge clk);
    end
  endtask

  initial begin
    int lows;
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(s_tready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);

    // Single 0x55 frame
    clear_rx();
    push(8'h55);
    s_tvalid = 1'b0;
    chk("single_count", 32'(fifo_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_idle_txd", 32'(txd), 32'd1);
    @(negedge clk);
    chk("single_popped", 32'(fifo_count), 32'd0);
    check_frame(8'h55);
    chk("single_busy_after", 32'(busy), 32'd0);
    chk("single_txd_after", 32'(txd), 32'd1);
    drain(1);

    // Back-to-back pair and frame pitch
    clear_rx();
    push(8'hA3);
    push(8'h0F);
    s_tvalid = 1'b0;
    drain(2);
    if (rx_t.size() >= 2) chk("pitch", 32'(rx_t[1] - rx_t[0]), 32'd41);
    else                  chk("pitch_frames", 32'(rx_t.size()), 32'd2);

    // Continuous stream of six bytes fills the FIFO
    clear_rx();
    for (int i = 1; i <= 6; i++) push(8'(i));
    s_tvalid = 1'b0;
    chk("stream_full", 32'(fifo_count), 32'd4);
    chk("stream_not_ready", 32'(s_tready), 32'd0);
    drain(6);

    // Push attempt on the pop edge of a full FIFO, with junk data while stalled
    clear_rx();
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    chk("full_count", 32'(fifo_count), 32'd4);
    s_tdata = 8'($urandom);
    lows = 0;
    while (fifo_count == 3'd4 && lows < 100) begin
      @(negedge clk);
      s_tdata = 8'($urandom);
      lows++;
    end
    chk("pop_edge_count", 32'(fifo_count), 32'd3);
    chk("pop_edge_ready", 32'(s_tready), 32'd1);
    chk("pop_edge_start", 32'(txd), 32'd0);
    s_tdata = 8'h77;
    exp_q.push_back(8'h77);
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("refill_count", 32'(fifo_count), 32'd4);
    drain(6);

    // Reset during data bit 3 with two bytes queued
    clear_rx();
    push(8'h5A);
    push(8'hC3);
    push(8'h3C);
    s_tvalid = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_bit3", 32'(txd), 32'd1);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 8'hEE;
    @(negedge clk);
    rst_n    = 1'b1;
    s_tvalid = 1'b0;
    chk("mid_rst_txd", 32'(txd), 32'd1);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(s_tready), 32'd1);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("no_frame_after_rst", 32'(lows), 32'd0);
    clear_rx();

    // Random traffic with random valid gaps
    for (int i = 0; i < 1000; i++) begin
      s_tvalid = 1'b0;
      if ($urandom_range(0, 15) == 0) repeat (60) @(negedge clk);
      else repeat ($urandom_range(0, 2)) @(negedge clk);
      push(8'($urandom));
    end
    s_tvalid = 1'b0;
    drain(1000);
    chk("count_bound", 32'(over_flag), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
